// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } if_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_next_pc.sv
// Redirect priority (branch over jump) and sequential PC+4 select.
module if_next_pc
  import instruction_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] redirect_target,
  output logic [31:0] pc_plus4
);

  // Branch wins when both redirects arrive together; targets are word aligned.
  always_comb begin
    redirect        = branch_taken | jump;
    redirect_target = (branch_taken ? branch_target : jump_target) & ~32'h3;
    pc_plus4        = pc + 32'd4;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, memory request handshake, stall hold buffer and
// redirect drain while an abandoned request is still outstanding.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BranchTaken_IN,
  input  logic [31:0] BranchTarget_IN,
  input  logic        Jump_IN,
  input  logic [31:0] JumpTarget_IN,
  output logic        IMemReq_OUT,
  output logic [31:0] IMemAddr_OUT,
  input  logic        IMemReady_IN,
  input  logic [31:0] IMemData_IN,
  output logic [31:0] Instruction_OUT,
  output logic [31:0] InstructionAddressPlus4_OUT,
  output logic        FetchBusy_OUT
);

  if_state_t   state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] hold_buf, hold_d;
  logic [31:0] pending, pending_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;

  if_next_pc u_next_pc (
    .pc              (pc),
    .branch_taken    (BranchTaken_IN),
    .branch_target   (BranchTarget_IN),
    .jump            (Jump_IN),
    .jump_target     (JumpTarget_IN),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_plus4        (pc_plus4)
  );

  // State, PC, hold buffer and pending target registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= FETCH;
      pc       <= RESET_PC & ~32'h3;
      hold_buf <= NOP;
      pending  <= 32'h0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      hold_buf <= hold_d;
      pending  <= pending_d;
    end
  end

  // Next-state and output decode; a redirect always suppresses the presented word.
  always_comb begin
    state_d                     = state;
    pc_d                        = pc;
    hold_d                      = hold_buf;
    pending_d                   = pending;
    IMemReq_OUT                 = 1'b0;
    IMemAddr_OUT                = pc;
    Instruction_OUT             = NOP;
    InstructionAddressPlus4_OUT = 32'h0;
    FetchBusy_OUT               = 1'b1;

    if (!RESET) begin
      case (state)
        FETCH: begin
          IMemReq_OUT = 1'b1;
          if (redirect) begin
            if (IMemReady_IN) begin
              pc_d = redirect_target;
            end else begin
              pending_d = redirect_target;
              state_d   = DRAIN;
            end
          end else if (IMemReady_IN) begin
            Instruction_OUT             = IMemData_IN;
            InstructionAddressPlus4_OUT = pc_plus4;
            FetchBusy_OUT               = 1'b0;
            if (STALL) begin
              hold_d  = IMemData_IN;
              state_d = HOLD;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_d    = redirect_target;
            state_d = FETCH;
          end else begin
            Instruction_OUT             = hold_buf;
            InstructionAddressPlus4_OUT = pc_plus4;
            FetchBusy_OUT               = 1'b0;
            if (!STALL) begin
              pc_d    = pc_plus4;
              state_d = FETCH;
            end
          end
        end
        DRAIN: begin
          // The abandoned request stays on the bus until memory answers it.
          IMemReq_OUT = 1'b1;
          if (redirect) pending_d = redirect_target;
          if (IMemReady_IN) begin
            pc_d    = redirect ? redirect_target : pending;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

  logic        CLOCK;
  logic        RESET;
  logic        STALL;
  logic        BranchTaken_IN;
  logic [31:0] BranchTarget_IN;
  logic        Jump_IN;
  logic [31:0] JumpTarget_IN;
  logic        IMemReq_OUT;
  logic [31:0] IMemAddr_OUT;
  logic        IMemReady_IN;
  logic [31:0] IMemData_IN;
  logic [31:0] Instruction_OUT;
  logic [31:0] InstructionAddressPlus4_OUT;
  logic        FetchBusy_OUT;

  int total = 0;
  int bad   = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .CLOCK                       (CLOCK),
    .RESET                       (RESET),
    .STALL                       (STALL),
    .BranchTaken_IN              (BranchTaken_IN),
    .BranchTarget_IN             (BranchTarget_IN),
    .Jump_IN                     (Jump_IN),
    .JumpTarget_IN               (JumpTarget_IN),
    .IMemReq_OUT                 (IMemReq_OUT),
    .IMemAddr_OUT                (IMemAddr_OUT),
    .IMemReady_IN                (IMemReady_IN),
    .IMemData_IN                 (IMemData_IN),
    .Instruction_OUT             (Instruction_OUT),
    .InstructionAddressPlus4_OUT (InstructionAddressPlus4_OUT),
    .FetchBusy_OUT               (FetchBusy_OUT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] tgt);
    STALL = 1'b0; BranchTaken_IN = 1'b0; Jump_IN = 1'b1; JumpTarget_IN = tgt;
    IMemReady_IN = 1'b1; IMemData_IN = 32'hDEAD_BEEF;
    tick();
    Jump_IN = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; STALL = 1'b0; BranchTaken_IN = 1'b0; Jump_IN = 1'b0;
    BranchTarget_IN = 32'h0; JumpTarget_IN = 32'h0;
    IMemReady_IN = 1'b1; IMemData_IN = 32'h1234_5678;
    tick(); tick(); #2;
    total++; if (IMemReq_OUT !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", IMemReq_OUT); end
    total++; if (Instruction_OUT !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", Instruction_OUT); end
    total++; if (InstructionAddressPlus4_OUT !== 32'h0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", InstructionAddressPlus4_OUT); end
    total++; if (FetchBusy_OUT !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", FetchBusy_OUT); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_addr = 32'(i) * 32'd4;
      IMemData_IN = 32'hC0DE_0000 + exp_addr;
      #2;
      total++; if (IMemAddr_OUT !== exp_addr || IMemReq_OUT !== 1'b1) begin bad++; $display("FAIL stream_addr%0d got=%h exp=%h", i, IMemAddr_OUT, exp_addr); end
      total++; if (InstructionAddressPlus4_OUT !== exp_addr + 32'd4) begin bad++; $display("FAIL stream_pc4_%0d got=%h exp=%h", i, InstructionAddressPlus4_OUT, exp_addr + 32'd4); end
      total++; if (Instruction_OUT !== 32'hC0DE_0000 + exp_addr || FetchBusy_OUT !== 1'b0) begin bad++; $display("FAIL stream_instr%0d got=%h exp=%h", i, Instruction_OUT, 32'hC0DE_0000 + exp_addr); end
      tick();
    end
  endtask

  task automatic test_wait();
    goto_pc(32'h10);
    IMemReady_IN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (IMemAddr_OUT !== 32'h10 || IMemReq_OUT !== 1'b1) begin bad++; $display("FAIL wait_addr%0d got=%h exp=00000010", i, IMemAddr_OUT); end
      total++; if (FetchBusy_OUT !== 1'b1 || Instruction_OUT !== 32'h0) begin bad++; $display("FAIL wait_busy%0d got=%b exp=1", i, FetchBusy_OUT); end
      tick();
    end
    IMemReady_IN = 1'b1; IMemData_IN = 32'hAAAA_0010;
    #2;
    total++; if (Instruction_OUT !== 32'hAAAA_0010 || FetchBusy_OUT !== 1'b0) begin bad++; $display("FAIL wait_word got=%h exp=aaaa0010", Instruction_OUT); end
    total++; if (InstructionAddressPlus4_OUT !== 32'h14) begin bad++; $display("FAIL wait_pc4 got=%h exp=00000014", InstructionAddressPlus4_OUT); end
    tick();
    IMemReady_IN = 1'b0; #2;
    total++; if (IMemAddr_OUT !== 32'h14) begin bad++; $display("FAIL wait_next got=%h exp=00000014", IMemAddr_OUT); end
    tick();
  endtask

  task automatic test_stall();
    goto_pc(32'h20);
    IMemReady_IN = 1'b1; IMemData_IN = 32'hBBBB_0020; STALL = 1'b1;
    #2;
    total++; if (Instruction_OUT !== 32'hBBBB_0020) begin bad++; $display("FAIL stall_first got=%h exp=bbbb0020", Instruction_OUT); end
    tick();
    IMemData_IN = 32'h5555_5555;
    #2;
    total++; if (IMemReq_OUT !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", IMemReq_OUT); end
    total++; if (Instruction_OUT !== 32'hBBBB_0020 || InstructionAddressPlus4_OUT !== 32'h24) begin bad++; $display("FAIL stall_hold got=%h/%h exp=bbbb0020/00000024", Instruction_OUT, InstructionAddressPlus4_OUT); end
    tick();
    STALL = 1'b0; #2;
    total++; if (Instruction_OUT !== 32'hBBBB_0020 || FetchBusy_OUT !== 1'b0) begin bad++; $display("FAIL stall_release got=%h exp=bbbb0020", Instruction_OUT); end
    tick();
    #2;
    total++; if (IMemAddr_OUT !== 32'h24 || IMemReq_OUT !== 1'b1) begin bad++; $display("FAIL stall_next got=%h exp=00000024", IMemAddr_OUT); end
    tick();
  endtask

  task automatic test_hold_redirect();
    goto_pc(32'h50);
    STALL = 1'b1; IMemReady_IN = 1'b1; IMemData_IN = 32'hCCCC_0050;
    tick();
    Jump_IN = 1'b1; JumpTarget_IN = 32'h60; #2;
    total++; if (Instruction_OUT !== 32'h0 || FetchBusy_OUT !== 1'b1) begin bad++; $display("FAIL holdredir_nop got=%h exp=00000000", Instruction_OUT); end
    tick();
    Jump_IN = 1'b0; STALL = 1'b0; #2;
    total++; if (IMemAddr_OUT !== 32'h60) begin bad++; $display("FAIL holdredir_addr got=%h exp=00000060", IMemAddr_OUT); end
    tick();
  endtask

  task automatic test_drain();
    goto_pc(32'h40);
    IMemReady_IN = 1'b0; BranchTaken_IN = 1'b1; BranchTarget_IN = 32'h100; #2;
    total++; if (IMemAddr_OUT !== 32'h40 || FetchBusy_OUT !== 1'b1) begin bad++; $display("FAIL drain_br got=%h exp=00000040", IMemAddr_OUT); end
    tick();
    BranchTaken_IN = 1'b0; Jump_IN = 1'b1; JumpTarget_IN = 32'h200; #2;
    total++; if (IMemAddr_OUT !== 32'h40 || IMemReq_OUT !== 1'b1 || Instruction_OUT !== 32'h0) begin bad++; $display("FAIL drain_hold got=%h exp=00000040", IMemAddr_OUT); end
    tick();
    Jump_IN = 1'b0; IMemReady_IN = 1'b1; IMemData_IN = 32'h7777_0040; #2;
    total++; if (Instruction_OUT !== 32'h0 || FetchBusy_OUT !== 1'b1 || IMemAddr_OUT !== 32'h40) begin bad++; $display("FAIL drain_discard got=%h exp=00000000", Instruction_OUT); end
    tick();
    #2;
    total++; if (IMemAddr_OUT !== 32'h200) begin bad++; $display("FAIL drain_target got=%h exp=00000200", IMemAddr_OUT); end
    tick();
  endtask

  task automatic test_priority();
    IMemReady_IN = 1'b1;
    BranchTaken_IN = 1'b1; BranchTarget_IN = 32'h80; Jump_IN = 1'b1; JumpTarget_IN = 32'h90; #2;
    total++; if (Instruction_OUT !== 32'h0 || FetchBusy_OUT !== 1'b1) begin bad++; $display("FAIL prio_nop got=%h exp=00000000", Instruction_OUT); end
    tick();
    BranchTaken_IN = 1'b0; Jump_IN = 1'b0; #2;
    total++; if (IMemAddr_OUT !== 32'h80) begin bad++; $display("FAIL prio_addr got=%h exp=00000080", IMemAddr_OUT); end
    tick();
    goto_pc(32'h123); #2;
    total++; if (IMemAddr_OUT !== 32'h120) begin bad++; $display("FAIL align_addr got=%h exp=00000120", IMemAddr_OUT); end
    tick();
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    IMemReady_IN = 1'b1; IMemData_IN = 32'hEEEE_FFFC; #2;
    total++; if (InstructionAddressPlus4_OUT !== 32'h0 || Instruction_OUT !== 32'hEEEE_FFFC) begin bad++; $display("FAIL wrap_pc4 got=%h exp=00000000", InstructionAddressPlus4_OUT); end
    tick();
    #2;
    total++; if (IMemAddr_OUT !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", IMemAddr_OUT); end
    tick();
  endtask

  task automatic test_reset_mid();
    goto_pc(32'h300);
    IMemReady_IN = 1'b0;
    tick();
    #1; RESET = 1'b1; #1;
    total++; if (IMemReq_OUT !== 1'b0 || FetchBusy_OUT !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b exp=0", IMemReq_OUT); end
    tick();
    RESET = 1'b0; #2;
    total++; if (IMemAddr_OUT !== 32'h0 || IMemReq_OUT !== 1'b1) begin bad++; $display("FAIL rstmid_addr got=%h exp=00000000", IMemAddr_OUT); end
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_hold_redirect();
    test_drain();
    test_priority();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have port: CLOCK  in  1  single system clock; all state updates on posedge.
REQ-003 SHALL have port: RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: STALL  in  1  hazard-unit freeze of fetch (same signal as the IF/ID stall).
REQ-005 SHALL have port: BranchTaken_IN  in  1  branch redirect request.
REQ-006 SHALL have port: BranchTarget_IN  in  32  branch target address.
REQ-007 SHALL have port: Jump_IN  in  1  jump redirect request.
REQ-008 SHALL have port: JumpTarget_IN  in  32  jump target address.
REQ-009 SHALL have port: IMemReq_OUT  out  1  instruction memory request.
REQ-010 SHALL have port: IMemAddr_OUT  out  32  instruction memory address.
REQ-011 SHALL have port: IMemReady_IN  in  1  memory data valid this cycle; completes the request.
REQ-012 SHALL have port: IMemData_IN  in  32  instruction word.
REQ-013 SHALL have port: Instruction_OUT  out  32  instruction to the IF/ID register; 32'h0 (NOP) when no valid instruction.
REQ-014 SHALL have port: InstructionAddressPlus4_OUT  out  32  PC of the presented instruction + 4; 0 with a NOP.
REQ-015 SHALL have port: FetchBusy_OUT  out  1  high in any cycle in which no valid instruction is presented.

Function
REQ-016 SHALL hold a 32-bit PC with bits [1:0] always 00; the low 2 bits of targets are ignored.
REQ-017 SHALL implement states FETCH, HOLD and DRAIN.
REQ-018 FETCH SHALL drive IMemReq_OUT=1 and IMemAddr_OUT=PC, and SHALL hold both stable until IMemReady_IN=1.
REQ-019 FETCH with ready and no redirect SHALL present IMemData_IN and PC+4 combinationally in the same cycle.
REQ-020 FETCH with ready, no redirect and STALL=0 SHALL set PC<=PC+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and stay in FETCH.
REQ-021 FETCH with ready, no redirect and STALL=1 SHALL capture the word into a hold buffer and go to HOLD with PC unchanged.
REQ-022 HOLD SHALL drive IMemReq_OUT=0 and present the buffered word with PC+4.
REQ-023 HOLD with STALL=0 SHALL set PC<=PC+4 and go to FETCH.
REQ-024 Redirect SHALL be BranchTaken_IN | Jump_IN; the target SHALL be BranchTarget_IN when both are asserted (branch wins); redirect is honoured regardless of STALL.
REQ-025 A redirect cycle SHALL present NOP with FetchBusy_OUT=1; any returned or buffered word SHALL be discarded.
REQ-026 Redirect in FETCH with ready, or in HOLD, SHALL set PC<=target and enter FETCH.
REQ-027 Redirect in FETCH without ready SHALL store the target in a pending register and enter DRAIN.
REQ-028 DRAIN SHALL keep the old request asserted and stable, present NOP, and overwrite the pending target on any further redirect (latest wins).
REQ-029 DRAIN with ready SHALL discard the data, set PC<=pending target (or the new target if a redirect coincides), and enter FETCH.
REQ-030 With IMemReady_IN tied to 1 and no stalls or redirects, throughput SHALL be one instruction per cycle with zero added latency.

Reset
REQ-031 RESET high SHALL immediately force PC=RESET_PC, state=FETCH, hold buffer=0 and pending target=0.
REQ-032 While RESET is high, IMemReq_OUT, Instruction_OUT and InstructionAddressPlus4_OUT SHALL be 0 and FetchBusy_OUT SHALL be 1.
REQ-033 RESET asserted mid-request SHALL abandon the request; the first request after release SHALL be to RESET_PC.

Structure
REQ-034 A shared package SHALL hold the state encoding (FETCH=2'b00, HOLD=2'b01, DRAIN=2'b10), the NOP constant 32'h0 and the default RESET_PC.
REQ-035 SHALL contain one sub-module, if_next_pc, a combinational redirect-priority / PC+4 select.

Verification
REQ-036 Release reset with RESET_PC=0x0 and ready=1 -> addresses 0x0, 0x4 and 0x8 on consecutive cycles; InstructionAddressPlus4_OUT = 0x4, 0x8, 0xC.
REQ-037 Ready=0 for 3 cycles at PC=0x10 -> IMemAddr_OUT held at 0x10, FetchBusy_OUT=1 for 3 cycles; word presented on cycle 4 and PC becomes 0x14.
REQ-038 STALL=1 for 2 cycles when data returns at PC=0x20 -> HOLD, request drops, same word presented each cycle; PC becomes 0x24 after STALL falls.
REQ-039 Branch to 0x100 while waiting at PC=0x40, then jump to 0x200 before ready -> address 0x40 held until ready; next request is 0x200 and no word is presented.
REQ-040 BranchTaken_IN and Jump_IN together (targets 0x80 and 0x90), and separately PC=0xFFFF_FFFC -> next PC is 0x80; the wrap case yields next PC 0x0.
